// File: rtl/m_mem_arb.sv
// Round-robin arbiter sharing one fixed-latency memory port between the
// instruction refill path and the data port. Completion pulses are registered.
module m_mem_arb #(
  parameter int LAT = 4,
  parameter int CW  = 3
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_i_re,
  input  logic [31:0] w_i_addr,
  output logic        r_i_oe,
  output logic [31:0] r_i_data,
  input  logic        w_d_re,
  input  logic        w_d_we,
  input  logic [31:0] w_d_addr,
  input  logic [31:0] w_d_wdata,
  output logic        r_d_oe,
  output logic [31:0] r_d_data,
  output logic        r_m_en,
  output logic        r_m_we,
  output logic [31:0] r_m_addr,
  output logic [31:0] r_m_wdata,
  input  logic [31:0] w_m_rdata,
  output logic        w_busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          own_q, own_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   idata_q, idata_d;
  logic [31:0]   ddata_q, ddata_d;
  logic          ioe_q, ioe_d;
  logic          doe_q, doe_d;
  logic          men_q, men_d;
  logic          mwe_q, mwe_d;
  logic          gnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    own_d   = own_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idata_d = idata_q;
    ddata_d = ddata_q;
    ioe_d   = 1'b0;
    doe_d   = 1'b0;
    men_d   = 1'b0;
    mwe_d   = 1'b0;
    gnt_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_i_re || w_d_re) begin
          // On a tie the port that did not win last time gets the grant
          gnt_d   = (w_i_re && w_d_re) ? ~last_q : w_d_re;
          own_d   = gnt_d;
          last_d  = gnt_d;
          we_d    = gnt_d & w_d_we;
          addr_d  = gnt_d ? w_d_addr : w_i_addr;
          wdata_d = gnt_d ? w_d_wdata : 32'h0;
          cnt_d   = CW'(LAT - 1);
          men_d   = 1'b1;
          mwe_d   = gnt_d & w_d_we;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (!we_q) begin
            if (own_q) ddata_d = w_m_rdata;
            else       idata_d = w_m_rdata;
          end
          if (own_q) doe_d = 1'b1;
          else       ioe_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      idata_q <= 32'h0;
      ddata_q <= 32'h0;
      ioe_q   <= 1'b0;
      doe_q   <= 1'b0;
      men_q   <= 1'b0;
      mwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      own_q   <= own_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idata_q <= idata_d;
      ddata_q <= ddata_d;
      ioe_q   <= ioe_d;
      doe_q   <= doe_d;
      men_q   <= men_d;
      mwe_q   <= mwe_d;
    end
  end

  assign r_i_oe    = ioe_q;
  assign r_i_data  = idata_q;
  assign r_d_oe    = doe_q;
  assign r_d_data  = ddata_q;
  assign r_m_en    = men_q;
  assign r_m_we    = mwe_q;
  assign r_m_addr  = addr_q;
  assign r_m_wdata = wdata_q;
  assign w_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_m_mem_arb.sv
// Directed bench for m_mem_arb: default latency, LAT=2 saturation and LAT=1 corner.
module tb_m_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rdata;
  logic        i_re, d_re, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_oe, d_oe, m_en, m_we, busy;
  logic [31:0] i_data, d_data, m_addr, m_wdata;

  logic        i_re2, d_re2;
  logic        i_oe2, d_oe2, m_en2, m_we2, busy2;
  logic [31:0] i_data2, d_data2, m_addr2, m_wdata2;

  logic        i_re3;
  logic        i_oe3, d_oe3, m_en3, m_we3, busy3;
  logic [31:0] i_data3, d_data3, m_addr3, m_wdata3;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] JUNK = 32'h5A5A_A5A5;

  always #5 clk = ~clk;

  m_mem_arb #(.LAT(4), .CW(3)) dut (
    .w_clk(clk), .w_rst(rst),
    .w_i_re(i_re), .w_i_addr(i_addr), .r_i_oe(i_oe), .r_i_data(i_data),
    .w_d_re(d_re), .w_d_we(d_we), .w_d_addr(d_addr), .w_d_wdata(d_wdata),
    .r_d_oe(d_oe), .r_d_data(d_data),
    .r_m_en(m_en), .r_m_we(m_we), .r_m_addr(m_addr), .r_m_wdata(m_wdata),
    .w_m_rdata(rdata), .w_busy(busy)
  );

  m_mem_arb #(.LAT(2), .CW(2)) dut2 (
    .w_clk(clk), .w_rst(rst),
    .w_i_re(i_re2), .w_i_addr(32'h0000_1000), .r_i_oe(i_oe2), .r_i_data(i_data2),
    .w_d_re(d_re2), .w_d_we(1'b0), .w_d_addr(32'h0000_2000), .w_d_wdata(32'h0),
    .r_d_oe(d_oe2), .r_d_data(d_data2),
    .r_m_en(m_en2), .r_m_we(m_we2), .r_m_addr(m_addr2), .r_m_wdata(m_wdata2),
    .w_m_rdata(rdata), .w_busy(busy2)
  );

  m_mem_arb #(.LAT(1), .CW(1)) dut3 (
    .w_clk(clk), .w_rst(rst),
    .w_i_re(i_re3), .w_i_addr(32'h0000_0300), .r_i_oe(i_oe3), .r_i_data(i_data3),
    .w_d_re(1'b0), .w_d_we(1'b0), .w_d_addr(32'h0), .w_d_wdata(32'h0),
    .r_d_oe(d_oe3), .r_d_data(d_data3),
    .r_m_en(m_en3), .r_m_we(m_we3), .r_m_addr(m_addr3), .r_m_wdata(m_wdata3),
    .w_m_rdata(rdata), .w_busy(busy3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rdata = JUNK;
    i_re = 0; d_re = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    i_re2 = 0; d_re2 = 0; i_re3 = 0;
    step(); step();
    chk("rst i_oe", i_oe, 0);
    chk("rst d_oe", d_oe, 0);
    chk("rst m_en", m_en, 0);
    chk("rst busy", busy, 0);
    chk("rst i_data", i_data, 0);
    chk("rst m_addr", m_addr, 0);
    rst = 1'b0;

    // single instruction read; this cycle is cycle 0
    i_re = 1; i_addr = 32'h40;
    for (int c = 1; c <= 6; c++) begin
      step();
      rdata = (c == 4) ? 32'h0050_0093 : JUNK;
      chk("t1 m_en", m_en, (c == 1));
      chk("t1 i_oe", i_oe, (c == 5));
      chk("t1 busy", busy, (c <= 5));
      if (c == 1) chk("t1 m_addr", m_addr, 32'h40);
      if (c == 5) begin
        chk("t1 i_data", i_data, 32'h0050_0093);
        i_re = 0;
      end
    end
    chk("t1 i_data hold", i_data, 32'h0050_0093);

    // simultaneous after reset: instruction first, data granted in cycle 6
    rst = 1; step(); rst = 0;
    i_re = 1; i_addr = 32'h80; d_re = 1; d_we = 0; d_addr = 32'h100;
    for (int c = 1; c <= 12; c++) begin
      step();
      rdata = (c == 4) ? 32'h1234_5678 : (c == 10) ? 32'hCAFE_0001 : JUNK;
      chk("t2 i_oe", i_oe, (c == 5));
      chk("t2 d_oe", d_oe, (c == 11));
      chk("t2 m_en", m_en, (c == 1 || c == 7));
      if (c == 1) chk("t2 addr I", m_addr, 32'h80);
      if (c == 7) chk("t2 addr D", m_addr, 32'h100);
      if (c == 6) chk("t2 idle", busy, 0);
      if (c == 5) i_re = 0;
      if (c == 11) d_re = 0;
    end
    chk("t2 i_data", i_data, 32'h1234_5678);
    chk("t2 d_data", d_data, 32'hCAFE_0001);

    // data write: no read-data capture
    d_re = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 6; c++) begin
      step();
      rdata = JUNK;
      chk("t3 m_en", m_en, (c == 1));
      chk("t3 m_we", m_we, (c == 1));
      chk("t3 d_oe", d_oe, (c == 5));
      chk("t3 d_data", d_data, 32'hCAFE_0001);
      if (c <= 4) chk("t3 m_wdata", m_wdata, 32'hDEAD_BEEF);
      if (c == 1) chk("t3 m_addr", m_addr, 32'h8);
      if (c == 5) begin d_re = 0; d_we = 0; end
    end

    // reset in BUSY cycle 2 of an instruction read, then the held request reissues
    i_re = 1; i_addr = 32'hC0;
    step(); step();
    rst = 1;
    step();
    rst = 0;
    chk("t4 busy", busy, 0);
    chk("t4 i_oe", i_oe, 0);
    chk("t4 m_en", m_en, 0);
    chk("t4 m_addr", m_addr, 0);
    chk("t4 i_data", i_data, 0);
    chk("t4 d_data", d_data, 0);
    for (int c = 1; c <= 6; c++) begin
      step();
      rdata = (c == 4) ? 32'h0BAD_F00D : JUNK;
      chk("t4 re m_en", m_en, (c == 1));
      chk("t4 re i_oe", i_oe, (c == 5));
      if (c == 5) begin
        chk("t4 re i_data", i_data, 32'h0BAD_F00D);
        i_re = 0;
      end
    end

    // late data request raised during DONE of an instruction access
    i_re = 1; i_addr = 32'h44;
    for (int c = 1; c <= 12; c++) begin
      step();
      rdata = (c == 10) ? 32'h7777_0002 : JUNK;
      chk("t5 i_oe", i_oe, (c == 5));
      chk("t5 d_oe", d_oe, (c == 11));
      chk("t5 m_en", m_en, (c == 1 || c == 7));
      if (c == 7) chk("t5 addr D", m_addr, 32'h200);
      if (c == 5) begin i_re = 0; d_re = 1; d_we = 0; d_addr = 32'h200; end
      if (c == 11) d_re = 0;
    end
    chk("t5 d_data", d_data, 32'h7777_0002);

    // saturation on LAT=2: strict I/D alternation, 4 cycles grant to grant
    rst = 1; step(); rst = 0;
    i_re2 = 1; d_re2 = 1;
    for (int c = 1; c <= 40; c++) begin
      step();
      chk("t6 m_en", m_en2, (c % 4 == 1));
      chk("t6 i_oe", i_oe2, (c % 8 == 3));
      chk("t6 d_oe", d_oe2, (c % 8 == 7));
      if (c % 4 == 1) chk("t6 owner addr", m_addr2, ((c / 4) % 2) ? 32'h2000 : 32'h1000);
    end
    i_re2 = 0; d_re2 = 0;

    // LAT=1: memory start and data capture in the same cycle
    rst = 1; step(); rst = 0;
    i_re3 = 1;
    for (int c = 1; c <= 3; c++) begin
      step();
      rdata = (c == 1) ? 32'h0000_0ABC : JUNK;
      chk("t7 m_en", m_en3, (c == 1));
      chk("t7 i_oe", i_oe3, (c == 2));
      chk("t7 busy", busy3, (c <= 2));
      if (c == 2) begin
        chk("t7 i_data", i_data3, 32'h0000_0ABC);
        i_re3 = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
